// File: rtl/nibble_serial_sub.sv
// Multi-cycle WIDTH-bit subtractor: one 4-bit lookahead slice per clock computes a - b
// as a + ~b + 1, carry registered between nibbles, with a start/ready/done handshake.
module nibble_serial_sub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowOut,
  output logic             overflow,
  output logic             negative,
  output logic             zero
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;
  logic             negative_q, negative_d;
  logic             zero_q, zero_d;

  // 4-bit generate/propagate lookahead slice on the nibble selected by idx.
  logic [3:0] nib_a, nib_b, g, p, sum;
  logic [4:0] c;

  assign nib_a = op_a_q[4*idx_q +: 4];
  assign nib_b = op_b_q[4*idx_q +: 4];
  assign g     = nib_a & nib_b;
  assign p     = nib_a ^ nib_b;
  assign c[0]  = carry_q;
  assign c[1]  = g[0] | (p[0] & c[0]);
  assign c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign sum   = p ^ c[3:0];

  // NOTE: every _d gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    diff_d     = diff_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    negative_d = negative_q;
    zero_d     = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = ~b;
          carry_d = 1'b1;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        diff_d[4*idx_q +: 4] = sum;
        carry_d              = c[4];
        idx_d                = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // op_b holds ~b, so equal stored MSBs means a and b had opposite signs.
          borrow_d   = ~c[4];
          overflow_d = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (sum[3] != op_a_q[WIDTH-1]);
          negative_d = sum[3];
          zero_d     = (diff_d == '0);
          state_d    = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      diff_q     <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      negative_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      diff_q     <= diff_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
      negative_q <= negative_d;
      zero_q     <= zero_d;
    end
  end

  // NOTE: operand copies carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    op_a_q <= op_a_d;
    op_b_q <= op_b_d;
  end

  assign ready     = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign diff      = diff_q;
  assign borrowOut = borrow_q;
  assign overflow  = overflow_q;
  assign negative  = negative_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Scoreboard bench for nibble_serial_sub: expected results are computed from the
// operands when start is driven and compared when done pulses.
module tb_nibble_serial_sub;

  localparam int WIDTH   = 32;
  localparam int LATENCY = WIDTH / 4 + 1;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             neg;
    logic             zero;
  } result_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             ready, done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out, overflow, negative, zero;

  int tests = 0;
  int fails = 0;
  result_t exp_q[$];

  nibble_serial_sub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done      (done),
    .diff      (diff),
    .borrowOut (borrow_out),
    .overflow  (overflow),
    .negative  (negative),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic result_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    result_t r;
    r.diff   = x - y;
    r.borrow = (x < y);
    r.ovf    = (x[WIDTH-1] != y[WIDTH-1]) && (r.diff[WIDTH-1] != x[WIDTH-1]);
    r.neg    = r.diff[WIDTH-1];
    r.zero   = (r.diff == '0);
    return r;
  endfunction

  // Expects to be called at a negedge with the DUT idle. disturb_n > 0 changes the
  // operands and pulses start at that negedge of the run.
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input int disturb_n);
    result_t exp, got;
    int      lat;
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_before_start: got %b want 1", ready);
    end
    a = x; b = y; start = 1'b1;
    exp_q.push_back(model(x, y));
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        tests++;
        if (ready !== 1'b0) begin
          fails++;
          $display("FAIL ready_in_run: got %b want 0", ready);
        end
      end
      if (disturb_n > 0 && n == disturb_n) begin
        a = $urandom; b = $urandom; start = 1'b1;
      end
      if (disturb_n > 0 && n == disturb_n + 1) start = 1'b0;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    tests++;
    if (lat != LATENCY) begin
      fails++;
      $display("FAIL latency a=%h b=%h: got %0d want %0d", x, y, lat, LATENCY);
    end
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_empty a=%h b=%h", x, y);
    end else begin
      exp = exp_q.pop_front();
      if (lat == LATENCY) begin
        got = '{diff, borrow_out, overflow, negative, zero};
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL result a=%h b=%h: got diff=%h bo=%b ov=%b ng=%b z=%b want diff=%h bo=%b ov=%b ng=%b z=%b",
                   x, y, got.diff, got.borrow, got.ovf, got.neg, got.zero,
                   exp.diff, exp.borrow, exp.ovf, exp.neg, exp.zero);
        end
      end
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      fails++;
      $display("FAIL after_done: got done=%b ready=%b want done=0 ready=1", done, ready);
    end
  endtask

  task automatic expect_no_done(input string name, input int cycles);
    int seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL %s: got %0d done pulses want 0", name, seen);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    tests++;
    if (ready !== 1'b1 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0 ||
        overflow !== 1'b0 || negative !== 1'b0 || zero !== 1'b0) begin
      fails++;
      $display("FAIL %s: got rdy=%b done=%b diff=%h bo=%b ov=%b ng=%b z=%b want 1 0 0 0 0 0 0",
               name, ready, done, diff, borrow_out, overflow, negative, zero);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_directed();
    run_op(32'h0000_0005, 32'h0000_0003, 0);
    run_op(32'h0000_0003, 32'h0000_0005, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 0);
    run_op(32'h1234_5678, 32'h1234_5678, 0);
    run_op(32'h0000_0000, 32'hFFFF_FFFF, 0);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) run_op($urandom, $urandom, 0);
  endtask

  task automatic test_start_during_run();
    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 3);
    expect_no_done("no_second_done", 12);
  endtask

  task automatic test_reset_mid_run();
    a = 32'hA5A5_5A5A; b = 32'h1111_2222; start = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 4; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check_reset_outputs("reset_mid_run");
    rst = 1'b0;
    expect_no_done("no_done_after_abort", 12);
  endtask

  task automatic test_reset_with_start();
    rst = 1'b1; start = 1'b1; a = 32'h0000_0009; b = 32'h0000_0004;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check_reset_outputs("reset_beats_start");
    expect_no_done("no_done_reset_start", 12);
    run_op(32'h0000_0009, 32'h0000_0004, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_during_run();
    test_reset_mid_run();
    test_reset_with_start();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nibble_serial_sub.md
# nibble_serial_sub

Multi-cycle WIDTH-bit subtractor computing a − b four bits per clock. Each cycle one nibble passes through a 4-bit carry-lookahead slice, with the carry registered between slices. It is the subtract-direction companion to the team's combinational lookahead adders, for datapaths that trade latency for area: ALU compare, address decrement, and loop counters. A start/ready/done handshake lets a controller FSM launch an operation and wait for the result.

## Interface
- WIDTH, 32: operand width in bits; must be a multiple of 4 and at least 8.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request a subtraction; sampled only when ready=1.
- a  in  WIDTH  minuend; sampled on the accepting edge only.
- b  in  WIDTH  subtrahend; sampled on the accepting edge only.
- ready  out  1  high in IDLE; block can accept start.
- done  out  1  one-cycle pulse; result outputs valid.
- diff  out  WIDTH  a − b modulo 2^WIDTH.
- borrowOut  out  1  unsigned a < b.
- overflow  out  1  signed overflow of a − b.
- negative  out  1  diff[WIDTH-1].
- zero  out  1  diff == 0.

## Operation
- States: IDLE, RUN, DONE. The nibble counter idx counts 0..WIDTH/4−1.
- IDLE: ready=1. If start=1 at an edge:
  - latch a into opA and ~b into opB;
  - set carry=1 (two's-complement subtract);
  - set idx=0 and go to RUN.
- RUN: ready=0. Each edge, slice idx computes opA[4idx+3:4idx] + opB[4idx+3:4idx] + carry using 4-bit generate/propagate lookahead.
  - The slice writes its 4 sum bits into diff[4idx+3:4idx].
  - The slice carry-out updates carry, and idx increments.
  - On the edge that processes idx = WIDTH/4−1, latch the flags and go to DONE:
    - borrowOut = ~carry_out;
    - overflow = (a[MSB] ≠ b[MSB]) && (diff[MSB] ≠ a[MSB]);
    - negative and zero from the completed diff.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Results and flags hold their values until the next accepted start. During RUN, diff shows partially updated nibbles and must not be consumed before done.
- start while in RUN or DONE is ignored, not queued.
- The operands are internal copies, so a and b may change freely after the accepting edge.
- rst=1 at any edge, including mid-RUN, has these effects:
  - state → IDLE;
  - diff, all flags, done, idx and carry → 0;
  - the operation in flight is abandoned with no done pulse;
  - rst has priority over start in the same cycle.

## Timing
- Reset values: ready=1, done=0, diff=0, borrowOut=0, overflow=0, negative=0, zero=0.
  - zero resets to 0 even though diff=0; zero is valid only from done onward.
- Accepting edge E0, where start=1 in IDLE, is followed by slice edges E1..E(WIDTH/4).
  - done=1 in the cycle after E(WIDTH/4).
  - Latency is WIDTH/4+1 cycles from the start cycle to the done cycle: 9 for WIDTH=32.
- ready drops in the cycle after E0 and returns the cycle after done.
- Minimum issue interval is WIDTH/4+2 cycles.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Critical path: one 4-bit lookahead slice plus the carry register.

## Test plan
- WIDTH=32, a=0x00000005, b=0x00000003, start one cycle.
  - done exactly 9 cycles after the start cycle.
  - diff=0x00000002; borrowOut=0, overflow=0, negative=0, zero=0.
- a=0x00000003, b=0x00000005.
  - diff=0xFFFFFFFE; borrowOut=1, negative=1, overflow=0, zero=0.
- a=0x80000000, b=0x00000001.
  - diff=0x7FFFFFFF; overflow=1, borrowOut=0, negative=0.
- a=b=0x12345678.
  - diff=0; zero=1, all other flags 0.
- a=0x00000000, b=0xFFFFFFFF.
  - diff=0x00000001; borrowOut=1, overflow=0.
- Disturbance sequence:
  - Change a/b and pulse start during RUN: the result still matches the original operands and there is no second done.
  - Start a new operation, then assert rst on the edge after E3: ready=1 and all outputs 0 the next cycle, and no done appears within 12 cycles.
  - Assert rst and start together: the block stays in IDLE.
